// File: rtl/reciprocal_restore.sv
// Restores an 11-bit magnitude from an 8-bit reciprocal code by computing
// floor(NUMER / code) with a bit-serial restoring divider, clamped to
// [VAL_MIN, VAL_MAX]. Saturated and out-of-range codes skip the divider.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// DIV   | one restoring step per clock, NUMER_W steps total
// DONE  | result held on out_val/out_sat until out_ready
module reciprocal_restore #(
    parameter int NUMER    = 38250,
    parameter int NUMER_W  = 16,
    parameter int VAL_MIN  = 192,
    parameter int VAL_MAX  = 1250,
    parameter int CODE_MIN = 30,
    parameter int CODE_SAT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_code,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [10:0] out_val,
    output logic        out_sat,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam int CNT_W = $clog2(NUMER_W);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t               state;
    logic [7:0]           divisor;
    logic [NUMER_W-1:0]   quo;
    logic [8:0]           rem;
    logic [CNT_W-1:0]     count;

    logic [9:0]           rem_shift;
    logic [9:0]           rem_next;
    logic                 rem_ge;
    logic [NUMER_W-1:0]   quo_next;
    logic [10:0]          clamp_val;
    logic                 clamp_sat;

    // One restoring step plus the clamp applied to the resulting quotient.
    // The remainder stays below the divisor, so the 10-bit shift never overflows.
    always_comb begin
        rem_shift = {rem, quo[NUMER_W-1]};
        rem_ge    = (rem_shift >= {2'b00, divisor});
        rem_next  = rem_ge ? (rem_shift - {2'b00, divisor}) : rem_shift;
        quo_next  = {quo[NUMER_W-2:0], rem_ge};
        clamp_val = quo_next[10:0];
        clamp_sat = 1'b0;
        if (quo_next < NUMER_W'(VAL_MIN)) begin
            clamp_val = 11'(VAL_MIN);
            clamp_sat = 1'b1;
        end else if (quo_next > NUMER_W'(VAL_MAX)) begin
            clamp_val = 11'(VAL_MAX);
            clamp_sat = 1'b1;
        end
    end

    // Handshake flags are decoded straight from the state register.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Sequencer: accept/bypass in IDLE, iterate in DIV, hold result in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            divisor   <= '0;
            quo       <= '0;
            rem       <= '0;
            count     <= '0;
            out_val   <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_code == 8'(CODE_SAT)) begin
                            out_val   <= 11'(VAL_MIN);
                            out_sat   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (in_code < 8'(CODE_MIN)) begin
                            // covers code 0 as well
                            out_val   <= 11'(VAL_MAX);
                            out_sat   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            divisor <= in_code;
                            quo     <= NUMER_W'(NUMER);
                            rem     <= '0;
                            count   <= CNT_W'(NUMER_W - 1);
                            state   <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem   <= 9'(rem_next);
                    quo   <= quo_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        out_val   <= clamp_val;
                        out_sat   <= clamp_sat;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reciprocal_restore.sv
// Directed bench for reciprocal_restore: an arithmetic reference model
// (plain integer division and clamp) feeds a scoreboard that a negedge
// monitor compares against the DUT on every cycle.
module tb_reciprocal_restore;

    localparam int NUMER    = 38250;
    localparam int VAL_MIN  = 192;
    localparam int VAL_MAX  = 1250;
    localparam int CODE_MIN = 30;
    localparam int CODE_SAT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_code;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] out_val;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    reciprocal_restore dut (
        .clk       (clk),
        .rst       (rst),
        .in_code   (in_code),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_val   (out_val),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int results = 0;
    int last_val = 0;
    int last_sat = 0;
    int res_vals[$];

    int exp_val_q[$];
    int exp_sat_q[$];
    int exp_lat_q[$];
    int acc_q[$];
    bit seen_first = 0;
    bit pend_hs = 0;
    int held_val = 0;
    int held_sat = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_bypass(input int code);
        return (code == CODE_SAT) || (code < CODE_MIN);
    endfunction

    function automatic int model_val(input int code);
        int q;
        if (code == CODE_SAT) return VAL_MIN;
        if (code < CODE_MIN) return VAL_MAX;
        q = NUMER / code;
        if (q < VAL_MIN) return VAL_MIN;
        if (q > VAL_MAX) return VAL_MAX;
        return q;
    endfunction

    function automatic int model_sat(input int code);
        int q;
        if (is_bypass(code)) return 1;
        q = NUMER / code;
        return ((q < VAL_MIN) || (q > VAL_MAX)) ? 1 : 0;
    endfunction

    // Edges after the accept edge until out_valid is visible.
    function automatic int model_lat(input int code);
        return is_bypass(code) ? 0 : 16;
    endfunction

    // Monitor: compares DUT against the scoreboard every cycle.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out_val", int'(out_val), 0);
            check("rst_busy", int'(busy), 0);
            exp_val_q.delete(); exp_sat_q.delete(); exp_lat_q.delete(); acc_q.delete();
            seen_first = 0;
            pend_hs = 0;
        end else begin
            check("in_ready_vs_busy", int'(in_ready), int'(!busy));
            if (pend_hs) begin
                check("hs_out_valid_drop", int'(out_valid), 0);
                check("hs_in_ready_rise", int'(in_ready), 1);
                check("hs_out_val_kept", int'(out_val), held_val);
                pend_hs = 0;
            end
            if (out_valid) begin
                if (exp_val_q.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else if (!seen_first) begin
                    check("latency", cyc - acc_q[0], exp_lat_q[0]);
                    check("out_val", int'(out_val), exp_val_q[0]);
                    check("out_sat", int'(out_sat), exp_sat_q[0]);
                    held_val = int'(out_val);
                    held_sat = int'(out_sat);
                    last_val = held_val;
                    last_sat = held_sat;
                    res_vals.push_back(held_val);
                    seen_first = 1;
                    results++;
                end else begin
                    check("hold_out_val", int'(out_val), held_val);
                    check("hold_out_sat", int'(out_sat), held_sat);
                    check("hold_in_ready", int'(in_ready), 0);
                end
                if (out_ready && exp_val_q.size() != 0) begin
                    void'(exp_val_q.pop_front()); void'(exp_sat_q.pop_front());
                    void'(exp_lat_q.pop_front()); void'(acc_q.pop_front());
                    seen_first = 0;
                    pend_hs = 1;
                end
            end else if (exp_val_q.size() != 0 && (cyc - acc_q[0]) > 40) begin
                check("result_timeout", 0, 1);
                void'(exp_val_q.pop_front()); void'(exp_sat_q.pop_front());
                void'(exp_lat_q.pop_front()); void'(acc_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_val_q.push_back(model_val(int'(in_code)));
                exp_sat_q.push_back(model_sat(int'(in_code)));
                exp_lat_q.push_back(model_lat(int'(in_code)));
                acc_q.push_back(cyc + 1);
            end
        end
    end

    task automatic send(input int code);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        in_code  = 8'(code);
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int r0);
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (results > r0) begin ok = 1; break; end
        end
        if (!ok) check("wait_result_timeout", 0, 1);
    endtask

    int dir_code[9] = '{198, 100, 200, 254, 199, 30, 29, 0, 255};
    int dir_val[9]  = '{193, 382, 192, 192, 192, 1250, 1250, 1250, 192};
    int dir_sat[9]  = '{0, 0, 1, 1, 0, 1, 1, 1, 1};
    int str_code[3] = '{198, 150, 60};
    int str_val[3]  = '{193, 255, 637};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int base;
        rst = 1'b1;
        in_code = 8'd0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_sat", int'(out_sat), 0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_out_valid", int'(out_valid), 0);

        // Directed codes, each pinned by a hand-computed result.
        for (int i = 0; i < 9; i++) begin
            check($sformatf("model_val_%0d", dir_code[i]), model_val(dir_code[i]), dir_val[i]);
            check($sformatf("model_sat_%0d", dir_code[i]), model_sat(dir_code[i]), dir_sat[i]);
            r0 = results;
            send(dir_code[i]);
            wait_result(r0);
            check($sformatf("val_code_%0d", dir_code[i]), last_val, dir_val[i]);
            check($sformatf("sat_code_%0d", dir_code[i]), last_sat, dir_sat[i]);
        end

        // Backpressure: result held for 10 cycles, new requests ignored.
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        r0 = results;
        send(100);
        wait_result(r0);
        check("bp_val", last_val, 382);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_code  = 8'd40;
            in_valid = i[0];
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_val", int'(out_val), 382);
            check("bp_out_valid", int'(out_valid), 1);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_no_extra_result", results, r0 + 1);

        // Reset in the middle of a divide.
        send(100);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_val", int'(out_val), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("postrst_in_ready", int'(in_ready), 1);
        r0 = results;
        send(50);
        wait_result(r0);
        check("postrst_val", last_val, 765);
        check("postrst_sat", last_sat, 0);

        // Back-to-back stream with out_ready tied high.
        repeat (2) @(posedge clk);
        base = res_vals.size();
        #1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bit ok;
            ok = 0;
            in_code = 8'(str_code[i]);
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (in_ready) begin ok = 1; break; end
            end
            if (!ok) check("stream_accept_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("stream_count", res_vals.size() - base, 3);
        for (int i = 0; i < 3; i++) begin
            if (base + i < res_vals.size())
                check($sformatf("stream_val_%0d", i), res_vals[base + i], str_val[i]);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reciprocal_restore.md
Name: reciprocal_restore

Overview:
Inverse of the spike-rate reciprocal compression stage. Takes an 8-bit reciprocal code and restores the 11-bit magnitude as val = floor(NUMER / code), clamped to [VAL_MIN, VAL_MAX]. The division is a multi-cycle restoring divider with valid/ready handshakes on both sides. It sits on the readback/decode path of the SNN datapath, feeding magnitude-domain consumers.

Parameters:
NUMER, 38250, dividend constant (val ≈ NUMER/code)
NUMER_W, 16, dividend/quotient width; must hold NUMER
VAL_MIN, 192, lower clamp; also the result for code == CODE_SAT
VAL_MAX, 1250, upper clamp; also the result for code == 0 or code < CODE_MIN
CODE_MIN, 30, smallest code that is divided
CODE_SAT, 255, saturation code; bypasses the divider

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
in_code  input  8  reciprocal code
in_valid  input  1  in_code valid
in_ready  output  1  block can accept; high only in IDLE
out_val  output  11  restored magnitude
out_sat  output  1  result clamped or bypassed
out_valid  output  1  out_val/out_sat valid
out_ready  input  1  downstream accepts
busy  output  1  state != IDLE

Behaviour:
- Reset: asynchronous, active-high; clock clk. Reset forces state IDLE, out_val=0, out_sat=0, out_valid=0, busy=0, internal remainder/quotient/count=0, and in_ready=1 after release. Reset mid-division aborts the division with no output.
- FSM states: IDLE, DIV, DONE.
- IDLE: in_ready=1. Accept at edge T when in_valid=1.
  - Bypass if in_code == CODE_SAT: go to DONE at edge T with out_val=VAL_MIN, out_sat=1.
  - Bypass if in_code == 0 or in_code < CODE_MIN: go to DONE at edge T with out_val=VAL_MAX, out_sat=1.
  - Otherwise latch the divisor, load quotient register=NUMER, remainder=0, count=NUMER_W-1, and go to DIV.
- Bypass outputs: out_valid=1 after edge T (latency 1).
- DIV: one restoring step per edge.
  - rem' = {rem, q[MSB]}; q shifts left.
  - If rem' >= divisor: rem = rem' - divisor and shift in 1; else keep rem' and shift in 0.
  - Remainder width is 9 bits.
  - On the step with count==0, register the clamped quotient into out_val, set out_sat (1 if clamped, 0 otherwise), set out_valid, and go to DONE.
  - Divide latency: out_valid high after edge T+NUMER_W (16 with defaults).
- Clamp rules:
  - q < VAL_MIN gives VAL_MIN.
  - q > VAL_MAX gives VAL_MAX.
  - Otherwise out_val = q[10:0].
- DONE: out_val/out_sat are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: out_valid goes to 0 and state goes to IDLE. out_val keeps its last value.
  - in_ready rises the cycle after the handshake; same-cycle back-to-back acceptance is not supported.
- in_valid is ignored outside IDLE, and in_code is not sampled after the accept edge.
- in_ready is a pure function of state; out_ready is never required for in_ready.
- No truncation surprises: quotient ≤ NUMER < 2^NUMER_W; out_val is always within [VAL_MIN, VAL_MAX].

Test Plan:
- Normal divide: in_code=198 accepted at T -> out_val=193, out_sat=0, out_valid rising after edge T+16; in_code=100 -> 382, out_sat=0.
- Low clamp: in_code=200 (q=191) -> out_val=192, out_sat=1; in_code=254 -> 192, out_sat=1; in_code=199 -> 192, out_sat=0.
- High clamp / bypass: in_code=30 (q=1275) -> 1250, out_sat=1 at 16-cycle latency; in_code=29 and in_code=0 -> 1250, out_sat=1 after 1 cycle; in_code=255 -> 192, out_sat=1 after 1 cycle.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_val stable, in_ready=0, new in_valid pulses ignored; assert out_ready -> out_valid drops next edge, in_ready=1 one cycle later.
- Reset mid-operation: assert rst at step 8 of in_code=100 -> outputs cleared immediately; after release, in_code=50 -> 765, out_sat=0.
- Back-to-back stream: codes 198, 150, 60 with out_ready=1 tied -> 193, 255, 637 in order, each separated by the 16-cycle divide plus 1-cycle turnaround.
